pipe_stage_skid: RTL and testbench
==================================

// Module: pipe_stage_skid
// PURPOSE
//  Generic parametrised pipeline stage register with valid/ready handshake and 2-entry skid buffer.
//  Replaces the per-stage fixed-width registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block.
//  Supports hazard-unit freeze, branch flush, in-order buffering, occupancy and stall-cycle statistics.
// PARAMETERS
//  DATA_W          64      payload width, e.g. {pc, instruction} for the IF stage
//  SKID_EN         1       1: two-entry skid buffer; 0: single entry, in_ready = out_ready when not full
//  CLEAR_ON_FLUSH  1       1: data registers load RESET_VAL on flush; 0: data held, only valid cleared
//  RESET_VAL       0       DATA_W-bit value loaded into the data registers on reset (and on flush if enabled)
//  STAT_W          16      width of the stall-cycle counter
// PORTS
//  clk          in   1        clock, rising edge
//  rst          in   1        asynchronous reset, active-low
//  freeze       in   1        hazard stall; blocks all transfers while high
//  flush        in   1        synchronous discard of every buffered entry
//  in_valid     in   1        upstream payload valid
//  in_data      in   DATA_W   upstream payload
//  in_ready     out  1        stage can accept; = (state!=FULL) & !freeze & !flush
//  out_valid    out  1        payload available; = (state!=EMPTY) & !freeze & !flush
//  out_data     out  DATA_W   head entry (main register), registered
//  out_ready    in   1        downstream accepts
//  level        out  2        occupancy 0..2 (0..1 when SKID_EN=0)
//  stall_cnt    out  STAT_W   cycles with out_valid & !out_ready, saturating
// BEHAVIOUR
//  - Reset (rst=0, async): state=EMPTY, main/skid data=RESET_VAL, level=0, stall_cnt=0, out_valid=0.
//    in_ready rises in the first cycle after rst deasserts (unless freeze/flush are high).
//  - in_fire  = in_valid & in_ready;  out_fire = out_valid & out_ready. Both are 0 while freeze or flush.
//  - Latency: data accepted in cycle N appears on out_data/out_valid in cycle N+1. Full throughput 1/clk.
//  - States (encoding is 2-bit, equal to level): EMPTY(0), ONE(1), FULL(2).
//    EMPTY: in_fire -> ONE, main<=in_data.
//    ONE:   in_fire & out_fire -> ONE, main<=in_data;  in_fire & !out_fire -> FULL, skid<=in_data;
//           !in_fire & out_fire -> EMPTY;  otherwise hold.
//    FULL:  in_ready=0; out_fire -> ONE, main<=skid; otherwise hold.
//  - SKID_EN=0: FULL unreachable; in ONE, in_ready = out_ready & !freeze & !flush (combinational path).
//  - Ordering: strict FIFO; skid entry is never emitted before main entry.
//  - freeze: state, data and level held exactly; stall_cnt not incremented (freeze is not a downstream stall).
//  - flush: next state=EMPTY, level=0; CLEAR_ON_FLUSH=1 -> main/skid<=RESET_VAL. Concurrent in_valid is
//    dropped (in_ready=0). flush overrides freeze. stall_cnt unaffected.
//  - stall_cnt increments when out_valid & !out_ready; saturates at 2^STAT_W-1, never wraps.
//  - Reset asserted mid-transfer: all entries discarded immediately, no partial state survives.
//  - out_data is undefined-free: always shows main register, even when out_valid=0.
// STRUCTURE
//  - Shared header pipe_defs.vh: state localparams ST_EMPTY/ST_ONE/ST_FULL, common RESET_VAL defaults
//    per stage (IF_W=64 etc.) so all pipe stage instances agree.
//  - Sub-module pipe_data_reg (DATA_W, RESET_VAL): async active-low reset, load enable, sync clear;
//    instantiated twice (main, skid; skid omitted when SKID_EN=0 via generate).
//  - Control FSM, handshake logic and stall counter live in this module.
// TESTING
//  1 Reset: hold rst=0 with in_valid=1 -> out_valid=0, level=0, out_data=RESET_VAL; in_ready=1 cycle after release.
//  2 Streaming: out_ready=1, push 0x1..0x8 back-to-back -> out_data 0x1..0x8 one cycle later, level stays 1.
//  3 Backpressure: out_ready=0, push 0xA,0xB,0xC -> level=2, in_ready=0, 0xC held upstream; stall_cnt counts;
//    release out_ready -> A,B,C emitted in order over 3 cycles.
//  4 Freeze: level=2, freeze=1 for 5 cycles with out_ready=1 -> no out_fire, level=2, stall_cnt unchanged.
//  5 Flush: level=2, flush=1 with in_valid=1 -> next cycle level=0, out_valid=0, data=RESET_VAL; input dropped.
//  6 Saturation: STAT_W=4, out_ready=0 for 20 cycles -> stall_cnt stops at 15; SKID_EN=0 build: level never > 1.

Source files
------------

// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for the pipe stage register.
// Every pipe stage instance uses these so that state names and defaults agree.
package pipe_stage_skid_pkg;

   // The state encoding equals the occupancy, so the level output is the state register itself.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   // Default widths: the IF stage carries {pc, instruction}.
   localparam int IF_W       = 64;
   localparam int DEF_STAT_W = 16;

endpackage

// File: rtl/pipe_data_reg.sv
// Payload register for one pipe stage entry.
// Resets to RESET_VAL. A synchronous clear takes priority over a load.
module pipe_data_reg #(
   parameter int                DATA_W    = 64,
   parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              clear,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q
);

   // Payload register: the reset value doubles as the flush value.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= RESET_VAL;
      end else if (clear) begin
         q <= RESET_VAL;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with a valid/ready handshake and an optional two-entry skid buffer.
// The main register is always the head entry. The skid register holds the second entry, which is
// taken when the downstream stalls while the upstream is still sending.
module pipe_stage_skid
   import pipe_stage_skid_pkg::*;
#(
   parameter int                DATA_W         = IF_W,
   parameter int                SKID_EN        = 1,
   parameter int                CLEAR_ON_FLUSH = 1,
   parameter logic [DATA_W-1:0] RESET_VAL      = '0,
   parameter int                STAT_W         = DEF_STAT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              freeze,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic [1:0]        level,
   output logic [STAT_W-1:0] stall_cnt
);

   state_t              state_q;
   state_t              state_d;
   logic                in_fire;
   logic                out_fire;
   logic                main_load;
   logic                clear_data;
   logic [DATA_W-1:0]   main_d;
   logic [DATA_W-1:0]   main_q;
   logic [DATA_W-1:0]   skid_q;
   logic [STAT_W-1:0]   stall_q;

   // Handshake: freeze and flush block both sides. Without a skid entry, a full stage can
   // only accept when its head leaves in the same cycle.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      if (!freeze && !flush) begin
         out_valid = (state_q != ST_EMPTY);
         case (state_q)
            ST_EMPTY: in_ready = 1'b1;
            ST_ONE:   in_ready = (SKID_EN != 0) ? 1'b1 : out_ready;
            default:  in_ready = 1'b0;
         endcase
      end
   end

   assign in_fire    = in_valid & in_ready;
   assign out_fire   = out_valid & out_ready;
   assign clear_data = flush & (CLEAR_ON_FLUSH != 0);

   // Next-state logic and the main register load. Only a FULL stage refills the head from the skid.
   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      main_load = 1'b0;
      main_d    = (state_q == ST_FULL) ? skid_q : in_data;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_fire) begin
                  state_d   = ST_ONE;
                  main_load = 1'b1;
               end
            end
            ST_ONE: begin
               if (in_fire && out_fire) begin
                  main_load = 1'b1;
               end else if (in_fire) begin
                  state_d = ST_FULL;
               end else if (out_fire) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (out_fire) begin
                  state_d   = ST_ONE;
                  main_load = 1'b1;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   // State register; reset discards every buffered entry at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Downstream stall statistic; saturates instead of wrapping. Freeze and flush force
   // out_valid low, so they never count as stalls.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_q <= '0;
      end else if (out_valid && !out_ready && (stall_q != {STAT_W{1'b1}})) begin
         stall_q <= stall_q + 1'b1;
      end
   end

   pipe_data_reg #(
      .DATA_W    (DATA_W),
      .RESET_VAL (RESET_VAL)
   ) u_main (
      .clk   (clk),
      .rst   (rst),
      .load  (main_load),
      .clear (clear_data),
      .d     (main_d),
      .q     (main_q)
   );

   generate
      if (SKID_EN != 0) begin : g_skid
         logic skid_load;
         // The second entry lands here when the head is stuck and a new one arrives.
         assign skid_load = (state_q == ST_ONE) & in_fire & ~out_fire;

         pipe_data_reg #(
            .DATA_W    (DATA_W),
            .RESET_VAL (RESET_VAL)
         ) u_skid (
            .clk   (clk),
            .rst   (rst),
            .load  (skid_load),
            .clear (clear_data),
            .d     (in_data),
            .q     (skid_q)
         );
      end else begin : g_no_skid
         // FULL is unreachable here, so the refill path never selects this value.
         assign skid_q = RESET_VAL;
      end
   endgenerate

   assign out_data  = main_q;
   assign level     = state_q;
   assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid. It drives a skid build and a single-entry build with
// a 4-bit stall counter from the same inputs. Both are compared against a queue-based reference model.
module tb_pipe_stage_skid;

   localparam logic [15:0] RV = 16'hDEAD;

   logic        clk = 1'b0;
   logic        rst;
   logic        freeze, flush, in_valid, out_ready;
   logic [15:0] in_data;
   logic        in_ready0, out_valid0, in_ready1, out_valid1;
   logic [15:0] out_data0, out_data1;
   logic [1:0]  level0, level1;
   logic [15:0] stall_cnt0;
   logic [3:0]  stall_cnt1;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pipe_stage_skid #(.DATA_W(16), .SKID_EN(1), .CLEAR_ON_FLUSH(1), .RESET_VAL(RV), .STAT_W(16)) dut0 (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready0), .out_valid(out_valid0), .out_data(out_data0), .out_ready(out_ready),
      .level(level0), .stall_cnt(stall_cnt0));

   pipe_stage_skid #(.DATA_W(16), .SKID_EN(0), .CLEAR_ON_FLUSH(1), .RESET_VAL(RV), .STAT_W(4)) dut1 (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready1), .out_valid(out_valid1), .out_data(out_data1), .out_ready(out_ready),
      .level(level1), .stall_cnt(stall_cnt1));

   // Reference model: each stage is a FIFO of bounded capacity plus the value last shown at the head.
   logic [15:0] q0[$];
   logic [15:0] q1[$];
   logic [15:0] shown0, shown1;
   int          sc0, sc1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit m_ov(int sz);
      return !freeze && !flush && sz > 0;
   endfunction

   // Two-entry stage accepts whenever there is room; one-entry stage also accepts if its head leaves.
   function automatic bit m_ir(int sz, bit skid);
      if (freeze || flush) return 1'b0;
      if (skid) return sz < 2;
      return sz == 0 || out_ready;
   endfunction

   task automatic model_reset();
      q0.delete();
      q1.delete();
      shown0 = RV;
      shown1 = RV;
      sc0 = 0;
      sc1 = 0;
   endtask

   task automatic model_check();
      check("lvl0",  32'(level0),     32'(q0.size()));
      check("ov0",   32'(out_valid0), 32'(m_ov(q0.size())));
      check("ir0",   32'(in_ready0),  32'(m_ir(q0.size(), 1'b1)));
      check("od0",   32'(out_data0),  32'(shown0));
      check("sc0",   32'(stall_cnt0), 32'(sc0));
      check("lvl1",  32'(level1),     32'(q1.size()));
      check("ov1",   32'(out_valid1), 32'(m_ov(q1.size())));
      check("ir1",   32'(in_ready1),  32'(m_ir(q1.size(), 1'b0)));
      check("od1",   32'(out_data1),  32'(shown1));
      check("sc1",   32'(stall_cnt1), 32'(sc1));
   endtask

   task automatic model_update();
      bit ov0 = m_ov(q0.size());
      bit ir0 = m_ir(q0.size(), 1'b1);
      bit ov1 = m_ov(q1.size());
      bit ir1 = m_ir(q1.size(), 1'b0);
      if (ov0 && !out_ready && sc0 < 65535) sc0++;
      if (ov1 && !out_ready && sc1 < 15) sc1++;
      if (flush) begin
         q0.delete();
         q1.delete();
         shown0 = RV;
         shown1 = RV;
      end else begin
         if (ov0 && out_ready) void'(q0.pop_front());
         if (in_valid && ir0) q0.push_back(in_data);
         if (q0.size() > 0) shown0 = q0[0];
         if (ov1 && out_ready) void'(q1.pop_front());
         if (in_valid && ir1) q1.push_back(in_data);
         if (q1.size() > 0) shown1 = q1[0];
      end
   endtask

   task automatic step();
      @(negedge clk);
      model_check();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic drive(input bit frz, input bit fl, input bit iv, input logic [15:0] d, input bit ordy);
      freeze    = frz;
      flush     = fl;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
   endtask

   // Directed vectors for the skid build: inputs, then the outputs expected in that same cycle.
   typedef struct {
      bit          frz, fl, iv;
      logic [15:0] d;
      bit          ordy;
      int          lvl;
      bit          ov, ir;
      logic [15:0] od;
      int          st;
   } vec_t;

   vec_t vq[$];

   task automatic add(input bit frz, input bit fl, input bit iv, input logic [15:0] d, input bit ordy,
                      input int lvl, input bit ov, input bit ir, input logic [15:0] od, input int st);
      vec_t v;
      v.frz = frz; v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
      v.lvl = lvl; v.ov = ov; v.ir = ir; v.od = od; v.st = st;
      vq.push_back(v);
   endtask

   initial begin
      rst = 1'b1;
      drive(0, 0, 1, 16'h1234, 0);
      model_reset();

      // Reset held with in_valid high: nothing may be captured.
      #2 rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("rst_ov0",  32'(out_valid0), 0);
         check("rst_lvl0", 32'(level0),     0);
         check("rst_od0",  32'(out_data0),  32'(RV));
         check("rst_sc0",  32'(stall_cnt0), 0);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      drive(0, 0, 0, 16'h0, 1);
      @(negedge clk);
      check("rel_ir0", 32'(in_ready0), 1);
      model_check();
      @(posedge clk);
      model_update();
      #1;

      // Streaming 1..8 with out_ready high.
      add(0, 0, 1, 16'h1, 1, 0, 0, 1, RV, 0);
      for (int i = 2; i <= 8; i++) add(0, 0, 1, 16'(i), 1, 1, 1, 1, 16'(i - 1), 0);
      add(0, 0, 0, 16'h0, 1, 1, 1, 1, 16'h8, 0);
      // Backpressure A, B, C.
      add(0, 0, 1, 16'hA, 0, 0, 0, 1, 16'h8, 0);
      add(0, 0, 1, 16'hB, 0, 1, 1, 1, 16'hA, 0);
      add(0, 0, 1, 16'hC, 0, 2, 1, 0, 16'hA, 1);
      add(0, 0, 1, 16'hC, 0, 2, 1, 0, 16'hA, 2);
      // Freeze while full with out_ready high: no transfer, no stall count.
      for (int i = 0; i < 5; i++) add(1, 0, 1, 16'hC, 1, 2, 0, 0, 16'hA, 3);
      // Release: A, B, C emitted in order.
      add(0, 0, 1, 16'hC, 1, 2, 1, 0, 16'hA, 3);
      add(0, 0, 1, 16'hC, 1, 1, 1, 1, 16'hB, 3);
      add(0, 0, 0, 16'h0, 1, 1, 1, 1, 16'hC, 3);
      // Flush while full with a concurrent input, which is dropped.
      add(0, 0, 1, 16'h11, 0, 0, 0, 1, 16'hC, 3);
      add(0, 0, 1, 16'h22, 0, 1, 1, 1, 16'h11, 3);
      add(0, 1, 1, 16'h33, 0, 2, 0, 0, 16'h11, 4);
      add(0, 0, 0, 16'h0, 1, 0, 0, 1, RV, 4);
      // Flush overrides freeze.
      add(0, 0, 1, 16'h44, 0, 0, 0, 1, RV, 4);
      add(1, 1, 1, 16'h55, 0, 1, 0, 0, 16'h44, 4);
      add(0, 0, 0, 16'h0, 0, 0, 0, 1, RV, 4);

      foreach (vq[i]) begin
         drive(vq[i].frz, vq[i].fl, vq[i].iv, vq[i].d, vq[i].ordy);
         @(negedge clk);
         check($sformatf("vec%0d_lvl", i), 32'(level0),     32'(vq[i].lvl));
         check($sformatf("vec%0d_ov", i),  32'(out_valid0), 32'(vq[i].ov));
         check($sformatf("vec%0d_ir", i),  32'(in_ready0),  32'(vq[i].ir));
         check($sformatf("vec%0d_od", i),  32'(out_data0),  32'(vq[i].od));
         check($sformatf("vec%0d_sc", i),  32'(stall_cnt0), 32'(vq[i].st));
         model_check();
         @(posedge clk);
         model_update();
         #1;
      end

      // Saturation: the 4-bit counter of the single-entry build stops at 15.
      drive(0, 0, 1, 16'h77, 0);
      step();
      drive(0, 0, 1, 16'h78, 0);
      for (int i = 0; i < 20; i++) begin
         step();
         check("lvl1_max", 32'(level1 <= 2'd1), 1);
      end
      @(negedge clk);
      check("sat_sc1", 32'(stall_cnt1), 15);

      // Reset in the middle of a full stage: everything goes at once.
      @(posedge clk);
      #3 rst = 1'b0;
      model_reset();
      #1;
      check("midrst_lvl0", 32'(level0),     0);
      check("midrst_ov0",  32'(out_valid0), 0);
      check("midrst_od0",  32'(out_data0),  32'(RV));
      check("midrst_sc0",  32'(stall_cnt0), 0);
      check("midrst_sc1",  32'(stall_cnt1), 0);
      @(posedge clk);
      #1 rst = 1'b1;
      drive(0, 0, 0, 16'h0, 1);
      step();

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
               16'($urandom), $urandom_range(0, 2) != 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
